// File: rtl/rx_msg_ctrl.sv
// MIL-STD-1553 remote-terminal receive-message sequencer: qualifies decoded words,
// drives the receive buffer capture strobes and reports message completion or abort.
module rx_msg_ctrl #(
  parameter int GAP_CYC  = 64,
  parameter bit BCAST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        R,
  input  logic [4:0]  rt_addr,
  input  logic        word_stb,
  input  logic        word_sync,
  input  logic        word_perr,
  input  logic [15:0] word_dat,
  output logic        ce,
  output logic        CW_DW,
  output logic        msg_busy,
  output logic        msg_done,
  output logic        msg_err,
  output logic [2:0]  err_code,
  output logic [5:0]  rx_cnt,
  output logic        tx_req,
  output logic        bcast
);

  localparam int             GW       = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_PARITY = 3'd1;
  localparam logic [2:0] ERR_CMD    = 3'd2;
  localparam logic [2:0] ERR_GAP    = 3'd3;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RX_DATA = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [5:0]    r_exp;
  logic [5:0]    r_rx_cnt;
  logic [GW-1:0] r_gap;
  logic [2:0]    r_err_code;
  logic          r_bcast;
  logic          r_done;
  logic          r_err;
  logic          r_tx;

  // Command word field decode
  logic [4:0] w_cmd_addr;
  logic       w_cmd_tr;
  logic [4:0] w_cmd_sa;
  logic [4:0] w_cmd_wc;
  logic       w_addr_bc;
  logic       w_accept;
  logic       w_mode;
  logic       w_data_exp;
  logic [5:0] w_exp_val;
  logic [5:0] w_cnt_inc;

  assign w_cmd_addr = word_dat[15:11];
  assign w_cmd_tr   = word_dat[10];
  assign w_cmd_sa   = word_dat[9:5];
  assign w_cmd_wc   = word_dat[4:0];
  assign w_addr_bc  = BCAST_EN && (w_cmd_addr == 5'd31);
  assign w_accept   = word_stb & word_sync & ~word_perr &
                      ((w_cmd_addr == rt_addr) | w_addr_bc);
  assign w_mode     = (w_cmd_sa == 5'd0) | (w_cmd_sa == 5'd31);
  // Mode codes carry a data word only when WC[4] is set; WC=0 means 32 words
  assign w_data_exp = ~w_cmd_tr & (~w_mode | w_cmd_wc[4]);
  assign w_exp_val  = w_mode ? 6'd1 :
                      ((w_cmd_wc == 5'd0) ? 6'd32 : {1'b0, w_cmd_wc});
  assign w_cnt_inc  = r_rx_cnt + 6'd1;

  logic       w_ce;
  logic       w_cmd_start;
  logic       w_data_cap;
  logic       w_done_set;
  logic       w_err_set;
  logic       w_tx_set;
  logic       w_err_ld;
  logic [2:0] w_err_nxt;
  logic       w_gap_clr;
  logic       w_gap_inc;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    w_cmd_start = 1'b0;
    w_data_cap  = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    w_tx_set    = 1'b0;
    w_err_ld    = 1'b0;
    w_err_nxt   = ERR_NONE;
    w_gap_clr   = 1'b0;
    w_gap_inc   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cmd_start = w_accept;
      end
      S_RX_DATA: begin
        if (word_stb) begin
          w_gap_clr = 1'b1;
          if (word_perr) begin
            w_err_set   = 1'b1;
            w_err_ld    = 1'b1;
            w_err_nxt   = ERR_PARITY;
            w_state_nxt = S_IDLE;
          end else if (word_sync) begin
            // A command mid-message aborts, then is judged as a fresh command
            w_err_set   = 1'b1;
            w_err_ld    = 1'b1;
            w_err_nxt   = ERR_CMD;
            w_state_nxt = S_IDLE;
            w_cmd_start = w_accept;
          end else begin
            w_ce       = 1'b1;
            w_data_cap = 1'b1;
            if (w_cnt_inc == r_exp) begin
              w_done_set  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end else if (r_gap == GAP_LAST) begin
          w_err_set   = 1'b1;
          w_err_ld    = 1'b1;
          w_err_nxt   = ERR_GAP;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_cmd_start) begin
      w_ce = 1'b1;
      if (w_data_exp) begin
        w_state_nxt = S_RX_DATA;
        w_gap_clr   = 1'b1;
      end else begin
        w_done_set = 1'b1;
        w_tx_set   = w_cmd_tr & ~w_addr_bc;
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_exp      <= 6'd0;
      r_rx_cnt   <= 6'd0;
      r_gap      <= '0;
      r_err_code <= ERR_NONE;
      r_bcast    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx       <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      r_tx   <= w_tx_set;

      if (w_cmd_start) begin
        r_bcast  <= w_addr_bc;
        r_rx_cnt <= 6'd0;
        r_exp    <= w_exp_val;
      end else if (w_data_cap) begin
        r_rx_cnt <= w_cnt_inc;
      end

      // An abort code outranks the clear from a command accepted in the same cycle
      if (w_err_ld) begin
        r_err_code <= w_err_nxt;
      end else if (w_cmd_start) begin
        r_err_code <= ERR_NONE;
      end

      if (w_gap_clr) begin
        r_gap <= '0;
      end else if (w_gap_inc) begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  assign ce       = w_ce & R;
  assign CW_DW    = w_ce & word_sync & R;
  assign msg_busy = (r_state == S_RX_DATA);
  assign msg_done = r_done;
  assign msg_err  = r_err;
  assign err_code = r_err_code;
  assign rx_cnt   = r_rx_cnt;
  assign tx_req   = r_tx;
  assign bcast    = r_bcast;

endmodule
